bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 8: bus address width.
- DATA_W, 32: bus data width.
- HOLD_MAX, 16: maximum cycles a master may keep the bus while the other master is waiting (only with BUS_ARBITER_TIMEOUT_EN).

REQ-002 Ports SHALL be, one per line:
- Clk, input, 1: the single clock; all state changes on its rising edge.
- reset_n, input, 1: reset, asynchronous and active-low.
- M0_req, input, 1: host master bus request.
- M0_wr, input, 1: host write strobe.
- M0_address, input, ADDR_W: host address.
- M0_dout, input, DATA_W: host write data.
- M1_req, input, 1: DMAC master bus request.
- M1_wr, input, 1: DMAC write strobe.
- M1_address, input, ADDR_W: DMAC address.
- M1_dout, input, DATA_W: DMAC write data.
- M0_grant, output, 1: host owns the bus.
- M1_grant, output, 1: DMAC owns the bus.
- S_wr, output, 1: muxed write strobe to the shared memory.
- S_address, output, ADDR_W: muxed address.
- S_din, output, DATA_W: muxed write data.

Function
REQ-003 The arbiter SHALL be a registered FSM with states IDLE, GRANT0 and GRANT1, encoded as a 2-bit enum.
- M0_grant=1 exactly in GRANT0.
- M1_grant=1 exactly in GRANT1.
- The grants are never both 1.

REQ-004 From IDLE, the FSM SHALL move to GRANT0 if M0_req=1 and M1_req=0, and to GRANT1 if M1_req=1 and M0_req=0. It stays in IDLE if neither request is high. Latency from request to grant is 1 cycle.

REQ-005 When M0_req and M1_req rise together in IDLE, the FSM SHALL grant the master that was NOT granted last (last-owner flag). After reset, the flag points to M1, so M0 wins the first tie.

REQ-006 In GRANTx, the grant SHALL be held while Mx_req=1. When Mx_req=0:
- if the other master is requesting, go directly to the other GRANT state with no IDLE bubble;
- otherwise go to IDLE.

REQ-007 The last-owner flag SHALL update on every entry into GRANT0 or GRANT1.

REQ-008 The output mux SHALL be combinational from the current state:
- GRANT0 drives M0_wr, M0_address and M0_dout onto S_wr, S_address and S_din.
- GRANT1 drives the M1 signals.
- IDLE drives S_wr=0, S_address=0 and S_din=0.

REQ-009 S_wr SHALL never be 1 unless a grant is active.

REQ-010 Request changes by a master that is not granted SHALL have no effect on the S_* outputs.

Reset
REQ-011 On asserting reset_n=0, regardless of the clock:
- the state SHALL be IDLE;
- the last-owner flag SHALL point to M1;
- the hold counter SHALL be 0;
- both grants and all S_* outputs SHALL be 0.

REQ-012 Reset asserted mid-grant SHALL drop the grant immediately. After release, arbitration restarts per REQ-004 and REQ-005.

Configuration
REQ-013 With macro BUS_ARBITER_TIMEOUT_EN defined:
- a hold counter SHALL count cycles spent in GRANTx while the other master requests, saturating at HOLD_MAX;
- when it reaches HOLD_MAX-1, the next edge SHALL transfer the grant to the waiting master even if Mx_req=1;
- the counter SHALL clear on every state change and whenever the other request is 0.

REQ-014 Without BUS_ARBITER_TIMEOUT_EN:
- no counter SHALL exist;
- a grant is held until it is released (non-preemptive).

Structure
REQ-015 The state enum (IDLE, GRANT0, GRANT1) and the master-index constants (M0=0, M1=1) SHALL live in the shared package bus_arb_pkg.

REQ-016 The S_* mux SHALL be a sub-module named bus_mux, instantiated once. The FSM and the counter SHALL stay in bus_arbiter.

Verification
REQ-017 Single requester: M1_req=1 from cycle 2 with M1_address=8'h10, M1_wr=1, M1_dout=32'hA5A5A5A5.
- Required: M1_grant=1 at cycle 3, with S_address=8'h10, S_din=32'hA5A5A5A5 and S_wr=1.
- Drop M1_req: M1_grant=0 one cycle later and S_* return to 0.

REQ-018 Simultaneous first request after reset, with M0_req and M1_req both 1:
- Required: M0 granted first.
- Release M0 with M1 still requesting: M1_grant=1 on the next cycle, with no IDLE cycle in between.

REQ-019 Alternation: both requests held and each released after 2 cycles of grant.
- Required: grants alternate M0, M1, M0 across 3 handoffs.

REQ-020 With BUS_ARBITER_TIMEOUT_EN and HOLD_MAX=4: M0 holds its request permanently and M1 requests from cycle 1 of M0's grant.
- Required: M1_grant=1 after exactly 4 grant cycles of M0.
- Without the macro: M0 keeps the grant indefinitely (check 50 cycles).

REQ-021 Reset mid-grant: assert reset_n=0 asynchronously while M1_grant=1.
- Required: M1_grant=0 and S_wr=0 before the next clock edge.
- After release with both requests high: M0 granted first.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared arbiter state encoding and master-index constants.
package bus_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/bus_mux.sv
// bus_mux: drives the shared memory bus from the granted master; idle bus is all zeros.
module bus_mux
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  state_e            state,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              s_wr,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_din
);
  always_comb begin
    s_wr      = state == GRANT0 ? m0_wr      : state == GRANT1 ? m1_wr      : 1'b0;
    s_address = state == GRANT0 ? m0_address : state == GRANT1 ? m1_address : '0;
    s_din     = state == GRANT0 ? m0_dout    : state == GRANT1 ? m1_dout    : '0;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with last-owner tie-break and seamless handoff.
// Define BUS_ARBITER_TIMEOUT_EN to preempt an owner after HOLD_MAX cycles while the other master waits.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 16
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              M0_req,
  input  logic              M0_wr,
  input  logic [ADDR_W-1:0] M0_address,
  input  logic [DATA_W-1:0] M0_dout,
  input  logic              M1_req,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M1_dout,
  output logic              M0_grant,
  output logic              M1_grant,
  output logic              S_wr,
  output logic [ADDR_W-1:0] S_address,
  output logic [DATA_W-1:0] S_din
);
  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   expire;

  if (HOLD_MAX < 2) begin : g_hold_chk
    $error("HOLD_MAX must be at least 2");
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          other_req;
  // Counts only while an owner keeps the bus and the other master is waiting.
  always_comb begin
    other_req = state_q == GRANT0 ? M1_req : state_q == GRANT1 ? M0_req : 1'b0;
    cnt_d     = (state_d != state_q || !other_req) ? '0 :
                cnt_q == CW'(HOLD_MAX) ? cnt_q : cnt_q + 1'b1;
  end
  assign expire = cnt_q == CW'(HOLD_MAX - 1);
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (M0_req && M1_req) ? (last_q == M1 ? GRANT0 : GRANT1) :
                         M0_req ? GRANT0 : M1_req ? GRANT1 : IDLE;
      GRANT0:  state_d = (M0_req && !(expire && M1_req)) ? GRANT0 : M1_req ? GRANT1 : IDLE;
      GRANT1:  state_d = (M1_req && !(expire && M0_req)) ? GRANT1 : M0_req ? GRANT0 : IDLE;
      default: state_d = IDLE;
    endcase
    last_d = state_d == GRANT0 ? M0 : state_d == GRANT1 ? M1 : last_q;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign M0_grant = state_q == GRANT0;
  assign M1_grant = state_q == GRANT1;

  bus_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .state     (state_q),
    .m0_wr     (M0_wr),
    .m0_address(M0_address),
    .m0_dout   (M0_dout),
    .m1_wr     (M1_wr),
    .m1_address(M1_address),
    .m1_dout   (M1_dout),
    .s_wr      (S_wr),
    .s_address (S_address),
    .s_din     (S_din)
  );
endmodule
